calibration_sequencer: RTL and testbench

Multi-step LED-address calibration sequencer for the camera pipeline. It runs ADDR_BITS calibration steps automatically: it requests each bit pattern from the LED driver, waits for the camera to settle, captures one frame, and shift-accumulates per-pixel bit decisions into an internal downsampled address map. The map carries a per-pixel validity flag and can be read back through a read port. It sits between the camera detect stage and the LED pattern driver, and its read port feeds the LED-position extraction logic.

---
 rtl/calibration_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_calibration_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calibration_sequencer
// Description : Steps through every LED address bit, captures one frame per
//               bit and shift-accumulates a downsampled {hit, addr} map.
// Revision    : 1.0 - initial release
// ============================================================================
module calibration_sequencer #(
    parameter int ADDR_BITS       = 10,
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int DS_SHIFT        = 2,
    parameter int WAIT_CYCLES     = 10000000,
    localparam int NPIX = (ACTIVE_H_PIXELS >> DS_SHIFT) * (ACTIVE_LINES >> DS_SHIFT),
    localparam int AW   = $clog2(NPIX),
    localparam int SW   = ($clog2(ADDR_BITS) > 1) ? $clog2(ADDR_BITS) : 1,
    localparam int CW   = $clog2(NPIX + 1)
) (
    input  logic                 clk_pixel,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 new_frame_in,
    input  logic                 detect_0,
    input  logic                 detect_1,
    output logic                 pattern_valid,
    output logic [SW-1:0]        pattern_bit,
    input  logic                 pattern_ack,
    output logic                 busy,
    output logic [2:0]           state,
    output logic                 step_done,
    output logic [CW-1:0]        step_conflicts,
    output logic                 done,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_valid,
    output logic [ADDR_BITS-1:0] rd_data,
    output logic                 rd_hit
);

    localparam int H_DS = ACTIVE_H_PIXELS >> DS_SHIFT;
    localparam int WCW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int MW   = ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_REQ_PATTERN = 3'd1,
        S_SETTLE      = 3'd2,
        S_WAIT_FRAME  = 3'd3,
        S_CAPTURE     = 3'd4,
        S_STEP_DONE   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [SW-1:0]  r_step;
    logic [SW-1:0]  w_step_next;
    logic [WCW-1:0] r_settle_cnt;
    logic [CW-1:0]  r_conf_cnt;
    logic [CW-1:0]  r_step_conflicts;

    logic [MW-1:0]  r_mem [NPIX];
    logic [MW-1:0]  r_rd_q;
    logic           r_rd_valid;

    logic           r_wr_pend;
    logic [AW-1:0]  r_wr_addr;
    logic           r_wr_bit;
    logic           r_wr_conf;
    logic           r_wr_first;

    logic           w_last_step;
    logic           w_settle_done;
    logic           w_sample;
    logic           w_conflict;
    logic           w_rd_accept;
    logic           w_step_done;
    logic [AW-1:0]  w_samp_addr;
    logic [AW-1:0]  w_ram_addr;
    logic [MW-1:0]  w_wr_data;

    assign w_last_step   = (r_step == SW'(ADDR_BITS - 1));
    assign w_settle_done = (r_settle_cnt == WCW'(WAIT_CYCLES - 1));

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_step_next   = r_step;
        pattern_valid = 1'b0;
        w_step_done   = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_REQ_PATTERN;
                    w_step_next  = '0;
                end
            end
            S_REQ_PATTERN: begin
                pattern_valid = 1'b1;
                if (pattern_ack) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_done) w_state_next = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (new_frame_in) w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (new_frame_in) w_state_next = S_STEP_DONE;
            end
            S_STEP_DONE: begin
                w_step_done = 1'b1;
                if (w_last_step) begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_step_next  = r_step + 1'b1;
                    w_state_next = S_REQ_PATTERN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // abort overrides every transition and suppresses all pulses
        if (abort) begin
            w_state_next  = S_IDLE;
            w_step_next   = '0;
            pattern_valid = 1'b0;
            w_step_done   = 1'b0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst || r_state != S_SETTLE) r_settle_cnt <= '0;
        else                            r_settle_cnt <= r_settle_cnt + 1'b1;
    end

    assign w_sample = (r_state == S_CAPTURE)
                   && (32'(hcount_in) < 32'(ACTIVE_H_PIXELS))
                   && (32'(vcount_in) < 32'(ACTIVE_LINES))
                   && (hcount_in[DS_SHIFT-1:0] == '0)
                   && (vcount_in[DS_SHIFT-1:0] == '0);
    assign w_samp_addr = AW'(hcount_in >> DS_SHIFT) + AW'(H_DS) * AW'(vcount_in >> DS_SHIFT);
    assign w_conflict  = ~(detect_0 ^ detect_1);
    assign w_rd_accept = rd_en && (r_state != S_CAPTURE) && !r_wr_pend;
    assign w_ram_addr  = w_sample ? w_samp_addr : rd_addr;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_conf_cnt <= '0;
        end else if (r_state != S_CAPTURE && w_state_next == S_CAPTURE) begin
            r_conf_cnt <= '0;
        end else if (w_sample && w_conflict && r_conf_cnt != CW'(NPIX)) begin
            r_conf_cnt <= r_conf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst)              r_step_conflicts <= '0;
        else if (w_step_done) r_step_conflicts <= r_conf_cnt;
    end

    // Read-modify-write: old entry is fetched in the sample cycle, merged next cycle
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_bit   <= 1'b0;
            r_wr_conf  <= 1'b0;
            r_wr_first <= 1'b0;
        end else begin
            r_wr_pend <= w_sample;
            if (w_sample) begin
                r_wr_addr  <= w_samp_addr;
                r_wr_bit   <= detect_1;
                r_wr_conf  <= w_conflict;
                r_wr_first <= (r_step == '0);
            end
        end
    end

    generate
        if (ADDR_BITS == 1) begin : g_merge_single
            assign w_wr_data = {~r_wr_conf, r_wr_bit};
        end else begin : g_merge_shift
            assign w_wr_data = r_wr_first
                ? {~r_wr_conf, {(ADDR_BITS-1){1'b0}}, r_wr_bit}
                : {r_rd_q[ADDR_BITS] & ~r_wr_conf, r_rd_q[ADDR_BITS-2:0], r_wr_bit};
        end
    endgenerate

    always_ff @(posedge clk_pixel) begin
        if (r_wr_pend) r_mem[r_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_rd_q     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_sample || w_rd_accept) r_rd_q <= r_mem[w_ram_addr];
        end
    end

    assign state          = r_state;
    assign busy           = (r_state != S_IDLE);
    assign pattern_bit    = SW'(ADDR_BITS - 1) - r_step;
    assign step_done      = w_step_done;
    assign step_conflicts = r_step_conflicts;
    assign rd_valid       = r_rd_valid;
    assign rd_data        = r_rd_q[ADDR_BITS-1:0];
    assign rd_hit         = r_rd_q[ADDR_BITS];

endmodule
`default_nettype wire

// File: tb/tb_calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calibration_sequencer
// Description : Self-checking bench: raster/LED-driver models, read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calibration_sequencer;

    localparam int ADDR_BITS = 3;
    localparam int NPIX      = 8;
    localparam int AW        = 3;
    localparam int SW        = 2;
    localparam int CW        = 4;
    localparam int H_TOTAL   = 12;
    localparam int V_TOTAL   = 6;

    logic                 clk_pixel = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [10:0]          hcount_in = '0;
    logic [9:0]           vcount_in = '0;
    logic                 new_frame_in = 1'b0;
    logic                 detect_0 = 1'b0;
    logic                 detect_1 = 1'b0;
    logic                 pattern_valid;
    logic [SW-1:0]        pattern_bit;
    logic                 pattern_ack = 1'b0;
    logic                 busy;
    logic [2:0]           state;
    logic                 step_done;
    logic [CW-1:0]        step_conflicts;
    logic                 done;
    logic                 rd_en = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 rd_valid;
    logic [ADDR_BITS-1:0] rd_data;
    logic                 rd_hit;

    calibration_sequencer #(
        .ADDR_BITS(3), .ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .DS_SHIFT(1), .WAIT_CYCLES(5)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .start(start), .abort(abort),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .new_frame_in(new_frame_in),
        .detect_0(detect_0), .detect_1(detect_1),
        .pattern_valid(pattern_valid), .pattern_bit(pattern_bit), .pattern_ack(pattern_ack),
        .busy(busy), .state(state), .step_done(step_done), .step_conflicts(step_conflicts),
        .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_hit(rd_hit)
    );

    always #5 clk_pixel = ~clk_pixel;

    int errors = 0;
    int checks = 0;
    int scene_sel = 0;
    bit inj_en = 1'b0;
    int ack_delay = 2;
    int drv_cnt = 0;
    logic [SW-1:0] led_bit = '0;
    int n_step_done = 0;
    int n_done = 0;
    int pix_idx;
    logic [ADDR_BITS-1:0] pix_scene;

    typedef struct { logic [AW-1:0] addr; logic [ADDR_BITS-1:0] data; logic hit; } rd_exp_t;
    typedef struct { int run; logic [AW-1:0] addr; logic [ADDR_BITS-1:0] data; logic hit; } rd_vec_t;
    rd_exp_t sb_q[$];
    rd_exp_t mon_e;
    rd_vec_t vecs[3*NPIX];

    function automatic logic [ADDR_BITS-1:0] scene_addr(input int sel, input int idx);
        if (sel == 0) return 3'b101;
        return 3'(7 - idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin tick(); n++; end
        if (state !== s) begin
            checks++; errors++;
            $display("FAIL %s: timeout, state=%0d expected %0d", name, state, s);
        end
    endtask

    task automatic wait_step_done(input int budget, input string name);
        int n = 0;
        while (step_done !== 1'b1 && n < budget) begin tick(); n++; end
        if (step_done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: timeout, step_done=%0b expected 1", name, step_done);
        end
    endtask

    // Raster generator plus scene: each downsampled pixel "owns" an LED address
    initial forever begin
        @(negedge clk_pixel);
        if (hcount_in == 11'(H_TOTAL - 1)) begin
            hcount_in = '0;
            vcount_in = (vcount_in == 10'(V_TOTAL - 1)) ? 10'd0 : vcount_in + 10'd1;
        end else begin
            hcount_in = hcount_in + 11'd1;
        end
        new_frame_in = (hcount_in == 11'd0) && (vcount_in == 10'(V_TOTAL - 1));
        pix_idx   = int'(hcount_in >> 1) + 4 * int'(vcount_in >> 1);
        pix_scene = scene_addr(scene_sel, pix_idx);
        detect_1  = pix_scene[led_bit];
        detect_0  = ~detect_1;
        if (inj_en && led_bit == 2'd1 && hcount_in == 11'd2 && vcount_in == 10'd0) begin
            detect_0 = 1'b1;
            detect_1 = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk_pixel);
        if (pattern_ack) begin
            pattern_ack = 1'b0;
            drv_cnt = 0;
        end else if (pattern_valid) begin
            drv_cnt++;
            if (drv_cnt >= ack_delay) begin
                pattern_ack = 1'b1;
                led_bit = pattern_bit;
            end
        end else begin
            drv_cnt = 0;
        end
    end

    initial forever begin
        @(posedge clk_pixel);
        #1;
        if (step_done === 1'b1) n_step_done++;
        if (done === 1'b1) n_done++;
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 data=%0h expected no response", rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("rd_data[%0d]", mon_e.addr), 32'(rd_data), 32'(mon_e.data));
                check($sformatf("rd_hit[%0d]", mon_e.addr), 32'(rd_hit), 32'(mon_e.hit));
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a, input logic [ADDR_BITS-1:0] d, input logic h);
        rd_exp_t e;
        e.addr = a; e.data = d; e.hit = h;
        sb_q.push_back(e);
        rd_addr = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_latency", 32'(rd_valid), 32'd1);
    endtask

    task automatic read_back(input int run);
        for (int i = 0; i < 3*NPIX; i++)
            if (vecs[i].run == run) do_read(vecs[i].addr, vecs[i].data, vecs[i].hit);
        tick();
        check($sformatf("sb_empty_run%0d", run), sb_q.size(), 0);
    endtask

    task automatic run_cal(input int sel, input bit inj, input bit probe_rd, input string tag);
        int sd0, d0;
        scene_sel = sel;
        inj_en = inj;
        sd0 = n_step_done;
        d0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_first_bit"}, 32'(pattern_bit), 32'(ADDR_BITS - 1));
        for (int s = 0; s < ADDR_BITS; s++) begin
            wait_state(3'd4, 400, {tag, "_capture"});
            if (probe_rd && s == 0) begin
                for (int i = 0; i < 4; i++) begin
                    rd_addr = 3'(i);
                    rd_en = 1'b1;
                    tick();
                    check("rd_drop_capture", 32'(rd_valid), 32'd0);
                end
                rd_en = 1'b0;
            end
            wait_step_done(200, {tag, "_step_done"});
            check($sformatf("%s_led_bit_s%0d", tag, s), 32'(led_bit), 32'(ADDR_BITS - 1 - s));
            check($sformatf("%s_done_s%0d", tag, s), 32'(done), (s == ADDR_BITS - 1) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("%s_conflicts_s%0d", tag, s), 32'(step_conflicts),
                  (inj && s == 1) ? 32'd1 : 32'd0);
        end
        check({tag, "_idle"}, 32'(state), 32'd0);
        check({tag, "_n_step_done"}, n_step_done - sd0, ADDR_BITS);
        check({tag, "_n_done"}, n_done - d0, 1);
    endtask

    initial begin
        int d0, n, hold_bad;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NPIX; i++) begin
                vecs[r*NPIX + i].run  = r;
                vecs[r*NPIX + i].addr = 3'(i);
                vecs[r*NPIX + i].data = scene_addr((r == 2) ? 1 : 0, i);
                vecs[r*NPIX + i].hit  = 1'b1;
                if (r == 1 && i == 1) begin
                    vecs[r*NPIX + i].data = 3'b111;
                    vecs[r*NPIX + i].hit  = 1'b0;
                end
            end
        end

        repeat (3) tick();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pattern_valid", 32'(pattern_valid), 32'd0);
        check("rst_pattern_bit", 32'(pattern_bit), 32'd2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step_done", 32'(step_done), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_step_conflicts", 32'(step_conflicts), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_hit", 32'(rd_hit), 32'd0);

        run_cal(0, 1'b0, 1'b0, "runA");
        read_back(0);
        run_cal(0, 1'b1, 1'b1, "runB");
        read_back(1);

        // abort during step-1 capture, then a clean restart
        scene_sel = 0;
        inj_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_step_done(400, "abort_step0");
        wait_state(3'd4, 400, "abort_capture1");
        repeat (10) tick();
        d0 = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pattern_valid", 32'(pattern_valid), 32'd0);
        repeat (5) tick();
        check("abort_no_done", n_done - d0, 0);
        run_cal(1, 1'b0, 1'b0, "runC");
        read_back(2);

        // pattern_ack held off; then exact settle length
        ack_delay = 20;
        start = 1'b1;
        tick();
        start = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (!(pattern_valid === 1'b1 && state === 3'd1)) hold_bad++;
            tick();
        end
        check("ack_hold", hold_bad, 0);
        wait_state(3'd2, 10, "hold_settle_entry");
        check("pv_drop_after_ack", 32'(pattern_valid), 32'd0);
        n = 0;
        while (state === 3'd2 && n < 50) begin n++; tick(); end
        check("settle_cycles", n, 5);
        check("settle_exit_state", 32'(state), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ack_delay = 2;
        check("hold_abort_state", 32'(state), 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
